// File: rtl/nibbler_mem_pkg.sv
// Shared widths, FSM encoding and requester ids for the nibbler RAM access path.
package nibbler_mem_pkg;

   localparam int DATA_WIDTH = 4;
   localparam int ADDR_WIDTH = 12;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETUP  = 2'd1,
      ST_STROBE = 2'd2,
      ST_HOLD   = 2'd3
   } state_t;

   localparam logic PORT0 = 1'b0;
   localparam logic PORT1 = 1'b1;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter: a tie goes to the port that was not granted last.
module rr_arbiter2
   import nibbler_mem_pkg::*;
(
   input  logic [1:0] i_req,
   input  logic       i_last_grant,
   input  logic       i_grant_en,
   output logic [1:0] o_gnt,
   output logic       o_gnt_id
);

   // NOTE: every output gets a default first, so no path through the block infers a latch.
   always_comb begin
      o_gnt    = 2'b00;
      o_gnt_id = PORT0;
      if (i_grant_en) begin
         case (i_req)
            2'b01: begin
               o_gnt    = 2'b01;
               o_gnt_id = PORT0;
            end
            2'b10: begin
               o_gnt    = 2'b10;
               o_gnt_id = PORT1;
            end
            2'b11: begin
               o_gnt_id = ~i_last_grant;
               o_gnt    = i_last_grant ? 2'b01 : 2'b10;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/ram_access_ctrl.sv
// Two-port access sequencer for the 4x4096 asynchronous RAM: every access is a
// registered setup/strobe/hold sequence so cs never overlaps an address or data change.
module ram_access_ctrl
   import nibbler_mem_pkg::*;
#(
   parameter int DATA_WIDTH = nibbler_mem_pkg::DATA_WIDTH,
   parameter int ADDR_WIDTH = nibbler_mem_pkg::ADDR_WIDTH
)(
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  r0_req,
   input  logic                  r0_we,
   input  logic [ADDR_WIDTH-1:0] r0_addr,
   input  logic [DATA_WIDTH-1:0] r0_wdata,
   output logic                  r0_ack,
   output logic [DATA_WIDTH-1:0] r0_rdata,
   input  logic                  r1_req,
   input  logic                  r1_we,
   input  logic [ADDR_WIDTH-1:0] r1_addr,
   input  logic [DATA_WIDTH-1:0] r1_wdata,
   output logic                  r1_ack,
   output logic [DATA_WIDTH-1:0] r1_rdata,
   output logic [ADDR_WIDTH-1:0] ram_addr,
   output logic                  ram_cs,
   output logic                  ram_we,
   output logic [DATA_WIDTH-1:0] ram_dout,
   output logic                  ram_doe,
   input  logic [DATA_WIDTH-1:0] ram_din
);

   state_t                r_state, w_next_state;
   logic                  r_last_grant, w_last_grant;
   logic                  r_lat_id, w_lat_id;
   logic                  r_lat_we, w_lat_we;
   logic [ADDR_WIDTH-1:0] r_ram_addr, w_ram_addr;
   logic [DATA_WIDTH-1:0] r_ram_dout, w_ram_dout;
   logic                  r_ram_cs, w_ram_cs;
   logic                  r_ram_we, w_ram_we;
   logic                  r_ram_doe, w_ram_doe;
   logic                  r_r0_ack, w_r0_ack;
   logic                  r_r1_ack, w_r1_ack;
   logic [DATA_WIDTH-1:0] r_r0_rdata, w_r0_rdata;
   logic [DATA_WIDTH-1:0] r_r1_rdata, w_r1_rdata;

   logic [1:0]            w_gnt;
   logic                  w_gnt_id;
   logic                  w_sel_we;
   logic [ADDR_WIDTH-1:0] w_sel_addr;
   logic [DATA_WIDTH-1:0] w_sel_wdata;

   rr_arbiter2 u_arb (
      .i_req        ({r1_req, r0_req}),
      .i_last_grant (r_last_grant),
      .i_grant_en   (r_state == ST_IDLE),
      .o_gnt        (w_gnt),
      .o_gnt_id     (w_gnt_id)
   );

   assign w_sel_we    = (w_gnt_id == PORT1) ? r1_we    : r0_we;
   assign w_sel_addr  = (w_gnt_id == PORT1) ? r1_addr  : r0_addr;
   assign w_sel_wdata = (w_gnt_id == PORT1) ? r1_wdata : r0_wdata;

   // Outputs are computed for the state being entered, then registered.
   always_comb begin
      w_next_state = r_state;
      w_last_grant = r_last_grant;
      w_lat_id     = r_lat_id;
      w_lat_we     = r_lat_we;
      w_ram_addr   = r_ram_addr;
      w_ram_dout   = r_ram_dout;
      w_ram_cs     = 1'b0;
      w_ram_we     = r_ram_we;
      w_ram_doe    = r_ram_doe;
      w_r0_ack     = 1'b0;
      w_r1_ack     = 1'b0;
      w_r0_rdata   = r_r0_rdata;
      w_r1_rdata   = r_r1_rdata;

      case (r_state)
         ST_IDLE: begin
            w_ram_we  = 1'b0;
            w_ram_doe = 1'b0;
            if (|w_gnt) begin
               w_lat_id     = w_gnt_id;
               w_last_grant = w_gnt_id;
               w_lat_we     = w_sel_we;
               w_ram_addr   = w_sel_addr;
               w_ram_we     = w_sel_we;
               w_ram_doe    = w_sel_we;
               if (w_sel_we) begin
                  w_ram_dout = w_sel_wdata;
               end
               w_next_state = ST_SETUP;
            end
         end
         ST_SETUP: begin
            w_ram_cs     = 1'b1;
            w_next_state = ST_STROBE;
         end
         ST_STROBE: begin
            // RAM output is sampled on the edge that drops cs, while it is still driven.
            if (r_lat_id == PORT1) begin
               w_r1_ack = 1'b1;
               if (!r_lat_we) begin
                  w_r1_rdata = ram_din;
               end
            end else begin
               w_r0_ack = 1'b1;
               if (!r_lat_we) begin
                  w_r0_rdata = ram_din;
               end
            end
            w_next_state = ST_HOLD;
         end
         ST_HOLD: begin
            w_ram_we     = 1'b0;
            w_ram_doe    = 1'b0;
            w_next_state = ST_IDLE;
         end
         default: begin
            w_next_state = ST_IDLE;
         end
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state      <= ST_IDLE;
         r_last_grant <= PORT1;
         r_lat_id     <= PORT0;
         r_lat_we     <= 1'b0;
         r_ram_addr   <= '0;
         r_ram_dout   <= '0;
         r_ram_cs     <= 1'b0;
         r_ram_we     <= 1'b0;
         r_ram_doe    <= 1'b0;
         r_r0_ack     <= 1'b0;
         r_r1_ack     <= 1'b0;
         r_r0_rdata   <= '0;
         r_r1_rdata   <= '0;
      end else begin
         r_state      <= w_next_state;
         r_last_grant <= w_last_grant;
         r_lat_id     <= w_lat_id;
         r_lat_we     <= w_lat_we;
         r_ram_addr   <= w_ram_addr;
         r_ram_dout   <= w_ram_dout;
         r_ram_cs     <= w_ram_cs;
         r_ram_we     <= w_ram_we;
         r_ram_doe    <= w_ram_doe;
         r_r0_ack     <= w_r0_ack;
         r_r1_ack     <= w_r1_ack;
         r_r0_rdata   <= w_r0_rdata;
         r_r1_rdata   <= w_r1_rdata;
      end
   end

   assign ram_addr = r_ram_addr;
   assign ram_cs   = r_ram_cs;
   assign ram_we   = r_ram_we;
   assign ram_dout = r_ram_dout;
   assign ram_doe  = r_ram_doe;
   assign r0_ack   = r_r0_ack;
   assign r1_ack   = r_r1_ack;
   assign r0_rdata = r_r0_rdata;
   assign r1_rdata = r_r1_rdata;

endmodule

// File: doc/ram_access_ctrl.md
Name: ram_access_ctrl

Overview:
- Sequences all accesses to the 4-bit x 4096 asynchronous tristate RAM.
- Arbitrates between two requesters: port 0 is the CPU fetch/operand path; port 1 is the program loader/IO path.
- Converts each synchronous req/ack transaction into a glitch-free setup/strobe/hold cycle on the RAM address, cs, we and data pins.
- Top level closes the bus with data = ram_doe ? ram_dout : 'z, and feeds the shared data net into ram_din.

Parameters:
- DATA_WIDTH, 4, RAM word width.
- ADDR_WIDTH, 12, RAM address width.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- r0_req  in  1  port 0 request; held high until r0_ack.
- r0_we  in  1  port 0 write (1) / read (0).
- r0_addr  in  ADDR_WIDTH  port 0 address.
- r0_wdata  in  DATA_WIDTH  port 0 write data.
- r0_ack  out  1  port 0 completion, one-cycle pulse.
- r0_rdata  out  DATA_WIDTH  port 0 read data, registered.
- r1_req, r1_we, r1_addr, r1_wdata, r1_ack, r1_rdata: same as port 0, for port 1.
- ram_addr  out  ADDR_WIDTH  RAM address.
- ram_cs  out  1  RAM chip select.
- ram_we  out  1  RAM write enable.
- ram_dout  out  DATA_WIDTH  data driven onto the RAM bus.
- ram_doe  out  1  bus drive enable for ram_dout.
- ram_din  in  DATA_WIDTH  RAM bus sampled value.

Behaviour:
- All outputs are registered.
- Reset values: state IDLE; ram_addr=0, ram_cs=0, ram_we=0, ram_dout=0, ram_doe=0; r0_ack=r1_ack=0; r0_rdata=r1_rdata=0; last_grant=1, so port 0 wins the first tie.
- States: IDLE -> SETUP -> STROBE -> HOLD -> IDLE. Fixed 4-cycle access; no back-to-back bypass.
- IDLE:
  - Neither req set: stay in IDLE.
  - One req set: grant that port.
  - Both set: grant the port not equal to last_grant.
  - On grant: latch granted addr/we/wdata and the port id; update last_grant; go to SETUP.
  - Request signals are sampled only in IDLE. Requester values after grant are ignored.
- SETUP: ram_addr=latched addr; ram_we=latched we; ram_cs=0. For writes, ram_dout=latched wdata and ram_doe=1. For reads, ram_doe=0.
- STROBE: ram_cs=1; address, we and data unchanged. A read samples ram_din at the end of STROBE into the granted port's rdata.
- HOLD:
  - ram_cs=0; addr, we, dout and doe held, so cs never overlaps an address or data change.
  - Granted port's ack=1 for exactly this cycle.
  - Granted port's rdata is valid from HOLD and holds until that port's next read completes. Writes leave rdata unchanged.
- Return to IDLE: ram_we=0, ram_doe=0. ram_addr holds its last value.
- Requester rule: deassert req on the edge where ack is seen. A req still high in the following IDLE is treated as a new request.
- Exactly one ack can be high in any cycle. r0_ack and r1_ack are never high simultaneously.
- Fairness: with both ports requesting continuously, grants alternate and each port is served at most 8 cycles after asserting req.
- Reset mid-access, in any state: next cycle is IDLE with all reset values.
  - No ack is issued and rdata is not updated.
  - If reset lands in STROBE of a write, the RAM word may or may not be written. That outcome is not checked.
- Address boundaries: no arithmetic on addresses; 0x000 and 0xFFF pass through unchanged.

Decomposition:
- Shared package nibbler_mem_pkg: DATA_WIDTH/ADDR_WIDTH constants, the state encoding (IDLE=0, SETUP=1, STROBE=2, HOLD=3), and the port-id constants.
- One sub-module: rr_arbiter2, a 2-way round-robin arbiter.
  - Inputs: req[1:0], last_grant, grant_en.
  - Outputs: gnt[1:0], gnt_id.
  - Instantiated once and used only in IDLE.

Test Plan:
- Reset: hold reset 2 cycles with r0_req=r1_req=1. All outputs stay 0 during reset and the first post-reset cycle shows IDLE. Port 0 wins the first grant.
- Port 0 write then port 1 read:
  - Port 0 writes 0xA to 0x123. Cycle+1: ram_addr=0x123, ram_we=1, ram_doe=1, ram_dout=0xA, ram_cs=0. Cycle+2: ram_cs=1. Cycle+3: ram_cs=0, r0_ack=1.
  - Port 1 then reads 0x123. r1_ack with r1_rdata=0xA; ram_doe stays 0 throughout.
- Simultaneous requests: both ports request writes (0x000<-0x1, 0xFFF<-0xF) twice in a row. Grant order is 0,1,0,1. Read-back gives 0x000=0x1 and 0xFFF=0xF.
- Starvation check: port 1 requests continuously for 40 cycles while port 0 issues 5 reads. Each port 0 ack arrives no later than 8 cycles after its req, and no cycle has both acks high.
- Reset during STROBE of a port 1 read: next cycle ram_cs=0 and state is IDLE. No r1_ack is issued and r1_rdata is unchanged.
- Grant-time latching: port 0 changes addr/wdata in the SETUP cycle. The RAM still sees the values latched at grant, and ram_addr never changes while ram_cs=1.
